// File: rtl/muldiv_pkg.sv
// Shared types and op decode helpers for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic is_div(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_rem(op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic signed_a(op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic signed_b(op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step, purely combinational.
// Multiply uses acc as {partial product hi, multiplier}; divide uses acc[W-1:0] as dividend/quotient.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic           is_div,
  input  logic [W-1:0]   opnd,
  input  logic [2*W-1:0] acc_in,
  input  logic [W-1:0]   rem_in,
  output logic [2*W-1:0] acc_out,
  output logic [W-1:0]   rem_out
);

  logic [W:0]   sum;
  logic [2*W:0] prod_sh;
  logic [W:0]   trial;
  logic [W:0]   diff;

  always_comb begin
    sum     = {1'b0, acc_in[2*W-1:W]} + (acc_in[0] ? {1'b0, opnd} : '0);
    prod_sh = {sum, acc_in[W-1:0]};
    // trial < 2*opnd, so the (W+1)-bit difference's top bit is exactly the borrow
    trial   = {rem_in, acc_in[W-1]};
    diff    = trial - {1'b0, opnd};
    if (is_div) begin
      acc_out = {acc_in[2*W-1:W], acc_in[W-2:0], ~diff[W]};
      rem_out = diff[W] ? trial[W-1:0] : diff[W-1:0];
    end else begin
      acc_out = prod_sh[2*W:1];
      rem_out = rem_in;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide beside the EX ALU; holds the pipeline via stall_req while iterating.
// Latency DATA_W/STEP_BITS+2 cycles (div-by-zero/overflow: 1); start ignored unless IDLE, flush aborts.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int STEP_BITS = 1,
  parameter int RD_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              flush,
  output logic              stall_req,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [RD_W-1:0]   rd_out
);

  localparam int N     = DATA_W / STEP_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(N);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] ALL_ONES = '1;
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_e state, state_n;
  op_e    op_in, op_q;
  logic   accept;

  logic                sa_q, sb_q;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   opnd_q, rem_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [RD_W-1:0]     rd_q;

  logic                sa_in, sb_in, div_zero, div_ovf, special, div_q;
  logic [DATA_W-1:0]   abs_a, abs_b, special_res;
  logic [2*DATA_W-1:0] acc_chain [STEP_BITS+1];
  logic [DATA_W-1:0]   rem_chain [STEP_BITS+1];
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo, rmd, fix_res;

  // Operand decode: magnitudes feed the unsigned core, signs are reapplied in FIX
  assign op_in       = op_e'(op);
  assign sa_in       = signed_a(op_in) & src_a[DATA_W-1];
  assign sb_in       = signed_b(op_in) & src_b[DATA_W-1];
  assign abs_a       = sa_in ? -src_a : src_a;
  assign abs_b       = sb_in ? -src_b : src_b;
  assign div_zero    = is_div(op_in) && (src_b == '0);
  assign div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                       (src_a == MOST_NEG) && (src_b == ALL_ONES);
  assign special     = div_zero || div_ovf;
  assign special_res = div_zero ? (is_rem(op_in) ? src_a : ALL_ONES)
                                : (is_rem(op_in) ? '0 : src_a);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !flush) begin
          accept  = 1'b1;
          state_n = special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (flush)               state_n = S_IDLE;
        else if (cnt == CNT_ONE) state_n = S_FIX;
      end
      S_FIX:   state_n = flush ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  assign stall_req = accept || (state == S_CALC) || (state == S_FIX);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  assign div_q        = is_div(op_q);
  assign acc_chain[0] = acc_q;
  assign rem_chain[0] = rem_q;

  for (genvar i = 0; i < STEP_BITS; i++) begin : g_step
    muldiv_step #(.W(DATA_W)) u_step (
      .is_div  (div_q),
      .opnd    (opnd_q),
      .acc_in  (acc_chain[i]),
      .rem_in  (rem_chain[i]),
      .acc_out (acc_chain[i+1]),
      .rem_out (rem_chain[i+1])
    );
  end

  always_comb begin
    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo  = (sa_q ^ sb_q) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rmd  = sa_q ? -rem_q : rem_q;
    case (op_q)
      OP_MUL:                       fix_res = prod[DATA_W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*DATA_W-1:DATA_W];
      OP_DIV, OP_DIVU:              fix_res = quo;
      default:                      fix_res = rmd;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= OP_MUL;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      cnt    <= '0;
      opnd_q <= '0;
      rem_q  <= '0;
      acc_q  <= '0;
      rd_q   <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            rd_q  <= rd_in;
            sa_q  <= sa_in;
            sb_q  <= sb_in;
            cnt   <= CNT_LOAD;
            rem_q <= '0;
            // Divide shifts the dividend out of acc low half; multiply shifts the multiplier out
            opnd_q <= is_div(op_in) ? abs_b : abs_a;
            acc_q  <= {{DATA_W{1'b0}}, (is_div(op_in) ? abs_a : abs_b)};
            if (special) begin
              result <= special_res;
              rd_out <= rd_in;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_chain[STEP_BITS];
          rem_q <= rem_chain[STEP_BITS];
          cnt   <= cnt - CNT_ONE;
        end
        S_FIX: begin
          if (!flush) begin
            result <= fix_res;
            rd_out <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench: radix-1 and radix-4 instances driven in lockstep, monitors check result/tag/done cycle.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    op    = 3'd0;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic [4:0]    rd_in = '0;

  logic          stall1, busy1, done1, stall4, busy4, done4;
  logic [W-1:0]  res1, res4;
  logic [4:0]    rd1, rd4;

  int cyc    = 0;
  int checks = 0;
  int fails  = 0;
  int stall_err;
  int t0;
  logic         stall_at0;
  logic [W-1:0] last1;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   rd;
    int           at;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  muldiv_unit #(.DATA_W(W), .STEP_BITS(1), .RD_W(5)) dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .rd_in(rd_in), .flush(flush), .stall_req(stall1), .busy(busy1), .done(done1),
    .result(res1), .rd_out(rd1)
  );

  muldiv_unit #(.DATA_W(W), .STEP_BITS(4), .RD_W(5)) dut4 (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .rd_in(rd_in), .flush(flush), .stall_req(stall4), .busy(busy4), .done(done4),
    .result(res4), .rd_out(rd4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && done1) begin
      if (q1.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL dut1 unexpected done: result %h at cycle %0d", res1, cyc);
      end else begin
        e = q1.pop_front();
        check("dut1 result", res1, e.res);
        check("dut1 rd_out", W'(rd1), W'(e.rd));
        check("dut1 done cycle", W'(cyc), W'(e.at));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset && done4) begin
      if (q4.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL dut4 unexpected done: result %h at cycle %0d", res4, cyc);
      end else begin
        e = q4.pop_front();
        check("dut4 result", res4, e.res);
        check("dut4 rd_out", W'(rd4), W'(e.rd));
        check("dut4 done cycle", W'(cyc), W'(e.at));
      end
    end
  end

  // Called at a negedge; start is high for exactly one cycle
  task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd, input logic [W-1:0] exp, input bit special,
                        input bit en1, input bit en4);
    exp_t e1, e4;
    op = o; src_a = a; src_b = b; rd_in = rd; start = 1'b1;
    t0 = cyc;
    e1.res = exp; e1.rd = rd; e1.at = cyc + (special ? 1 : 34);
    e4.res = exp; e4.rd = rd; e4.at = cyc + (special ? 1 : 10);
    if (en1) q1.push_back(e1);
    if (en4) q4.push_back(e4);
    #1 stall_at0 = stall1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q1.size() != 0 || q4.size() != 0) begin
      fails++;
      $display("FAIL drain timeout: pending dut1 %0d dut4 %0d", q1.size(), q4.size());
      q1.delete();
      q4.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [4:0] rd, input logic [W-1:0] exp, input bit special);
    launch(o, a, b, rd, exp, special, 1'b1, 1'b1);
    drain();
    last1 = exp;
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", W'(busy1), '0);
    check("reset stall_req", W'(stall1), '0);
    check("reset done", W'(done1), '0);
    check("reset result", res1, '0);
    check("reset rd_out", W'(rd1), '0);
    check("reset result dut4", res4, '0);
    reset = 1'b1;
    @(negedge clk);

    // MUL 7 * -3 with stall profile
    launch(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 1'b0, 1'b1, 1'b1);
    stall_err = 0;
    for (int k = 1; k < 34; k++) begin
      if (stall1 !== 1'b1) stall_err++;
      @(negedge clk);
    end
    check("mul stall cycle 0", W'(stall_at0), 32'd1);
    check("mul stall cycles 1-33 low count", W'(stall_err), 32'd0);
    check("mul stall cycle 34", W'(stall1), 32'd0);
    drain();
    last1 = 32'hFFFFFFEB;

    run(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 1'b0);
    run(OP_MULH,   32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 1'b0);
    run(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 1'b0);
    run(OP_DIVU,   32'd5,        32'd0,        5'd4,  32'hFFFFFFFF, 1'b1);
    run(OP_REMU,   32'd5,        32'd0,        5'd6,  32'd5,        1'b1);
    run(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd7,  32'h80000000, 1'b1);
    run(OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd8,  32'd0,        1'b1);
    run(OP_DIV,    32'hFFFFFFF9, 32'd0,        5'd10, 32'hFFFFFFFF, 1'b1);
    run(OP_REM,    32'hFFFFFFF9, 32'd0,        5'd11, 32'hFFFFFFF9, 1'b1);
    run(OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFD, 1'b0);
    run(OP_REM,    32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFF, 1'b0);
    run(OP_DIVU,   32'd100,      32'd7,        5'd14, 32'd14,       1'b0);
    run(OP_REMU,   32'd100,      32'd7,        5'd15, 32'd2,        1'b0);

    // Flush at cycle 10: radix-1 aborts, radix-4 is already in DONE and still completes
    launch(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy cleared", W'(busy1), '0);
    check("flush result held", res1, last1);
    check("flush stall_req", W'(stall1), '0);
    @(negedge clk);
    run(OP_MUL, 32'h00012345, 32'h00000100, 5'd16, 32'h01234500, 1'b0);

    // Asynchronous reset mid-multiply
    launch(OP_MUL, 32'd3, 32'd4, 5'd17, 32'd12, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async reset busy", W'(busy1), '0);
    check("async reset stall_req", W'(stall1), '0);
    check("async reset result", res1, '0);
    check("async reset busy dut4", W'(busy4), '0);
    q1.delete();
    q4.delete();
    op = OP_DIVU; src_a = 32'd9; src_b = 32'd3; start = 1'b1;
    repeat (2) @(negedge clk);
    check("start under reset ignored", W'(busy1), '0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    run(OP_DIVU, 32'd9, 32'd3, 5'd18, 32'd3, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide engine that sits beside the EX-stage ALU of the 5-stage pipelined datapath. It accepts one M-extension operation from ID/EX, holds the pipeline through a stall request while it iterates, and returns a registered result tagged with the destination register. Datapath width and radix (bits retired per cycle) are parameters; the unit supports flush on branch/jump redirect.

Parameters:
DATA_W, 32, operand/result width (even, >= 8)
STEP_BITS, 1, quotient/multiplier bits processed per CALC cycle; must divide DATA_W (1, 2 or 4)
RD_W, 5, destination register tag width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  issue request; qualified only in IDLE
op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
src_a  in  DATA_W  rs1 operand (post-forwarding)
src_b  in  DATA_W  rs2 operand (post-forwarding)
rd_in  in  RD_W  destination tag
flush  in  1  abort in-flight operation (PcSel redirect)
stall_req  out  1  holds PC, IF/ID and ID/EX
busy  out  1  operation in flight
done  out  1  one-cycle pulse; result/rd_out valid
result  out  DATA_W  registered result
rd_out  out  RD_W  registered destination tag

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy, done, result, rd_out, internal accumulators all 0; stall_req 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 and flush=0 -> latch operands, op, rd_in; sign-strip operands per op (MULH/DIV/REM both signed; MULHSU a signed only); load counter N=DATA_W/STEP_BITS.
  - DIV/REM special cases bypass CALC -> DONE next cycle:
    - divisor 0: quotient all-ones, remainder = src_a.
    - signed overflow (a = most-negative, b = -1): quotient = a, remainder 0.
  - Otherwise -> CALC.
- CALC: one step per cycle (shift-add multiply on 2*DATA_W accumulator / restoring divide), STEP_BITS bits per step; counter decrements; at count 1 -> FIX.
- FIX: apply sign correction (negate product if operand signs differ; quotient sign = sa^sb; remainder sign = sa); select low/high half or quotient/remainder -> register result -> DONE.
- DONE: done=1 for exactly this cycle; -> IDLE. A start in DONE is ignored (pipeline is advancing). Next operation is accepted on the following IDLE cycle.
- Latency, start at cycle 0: normal ops done at cycle N+2 (DATA_W=32, STEP_BITS=1: cycle 34; STEP_BITS=4: cycle 10). Special cases: done at cycle 1.
- busy = (state != IDLE).
- stall_req = (state==IDLE && start && !flush) || state==CALC || state==FIX. It is combinational so the issuing instruction holds in ID/EX the same cycle. Deasserted in DONE.
- start while busy: ignored, no state change.
- flush: any non-IDLE state -> IDLE next edge. done is not asserted for the aborted op; result and rd_out hold their previous values. flush together with start in IDLE: flush wins, nothing accepted. flush in DONE: done still pulses (already committed).
- Reset mid-operation: immediate IDLE, outputs cleared, no done.
- All arithmetic is modulo 2^DATA_W on outputs. Internal product width is 2*DATA_W; remainder width is DATA_W+1.

Decomposition:
- Package muldiv_pkg:
  - op enum (funct3 encodings above).
  - state enum {IDLE, CALC, FIX, DONE}.
  - helper function is_div(op).
  - constants for special-case values derived from DATA_W.
- Sub-module muldiv_step: combinational single-radix step (shift-add / restore-subtract), replicated STEP_BITS times inside the CALC datapath.

Test Plan:
- MUL src_a=7, src_b=0xFFFFFFFD (-3), DATA_W=32, STEP_BITS=1 -> result 0xFFFFFFEB at cycle 34; stall_req high cycles 0-33, low at 34; done single pulse; rd_out = rd_in.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, done at cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, done at cycle 1.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; STEP_BITS=4 build gives same results with done at cycle 10.
- flush asserted at cycle 10 of a DIV -> IDLE at cycle 11, busy 0, no done, result unchanged. New MUL started at cycle 12 completes at cycle 46.
- reset driven low at cycle 5 of a MUL (asynchronous, between edges) -> busy/stall_req/result drop immediately. start ignored while reset low; after release, DIVU 9/3 -> 3.
